// File: rtl/camera_frame_crop.sv
// Camera frame crop: window cropping and frame decimation
// on a valid/ready pixel stream with a single output register.
module camera_frame_crop #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              cfg_en_i,
  input  logic              cfg_slice_en_i,
  input  logic [CNT_W-1:0]  cfg_ll_x_i,
  input  logic [CNT_W-1:0]  cfg_ll_y_i,
  input  logic [CNT_W-1:0]  cfg_ur_x_i,
  input  logic [CNT_W-1:0]  cfg_ur_y_i,
  input  logic [CNT_W-1:0]  cfg_rowlen_i,
  input  logic              cfg_drop_en_i,
  input  logic [5:0]        cfg_drop_val_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [DATA_W-1:0] pix_data_i,
  input  logic              pix_sof_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_sof_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DROP   = 2'd2;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]        state_q, state_d, st_cur;
  logic [5:0]        fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]  cur_x, cur_y;
  logic              sl_q, sl_d;
  logic [CNT_W-1:0]  llx_q, llx_d, lly_q, lly_d;
  logic [CNT_W-1:0]  urx_q, urx_d, ury_q, ury_d;
  logic [CNT_W-1:0]  rl_q, rl_d;
  logic              pend_q, pend_d;
  logic              ov_q, ov_d;
  logic [DATA_W-1:0] od_q, od_d;
  logic              os_q, os_d;
  logic              acc, new_frame, keep, in_win, emit;

  assign pix_ready_o = ~ov_q | out_ready_i;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_sof_o   = os_q;

  // Frame decision, coordinate tracking and output register next state.
  // x_q/y_q hold the coordinates the next accepted pixel will carry.
  always_comb begin
    acc       = pix_valid_i & pix_ready_o;
    new_frame = acc & cfg_en_i & pix_sof_i;
    keep      = ~cfg_drop_en_i | (fcnt_q == 6'd0);
    st_cur    = state_q;
    fcnt_d    = fcnt_q;
    sl_d      = sl_q;
    llx_d     = llx_q;
    lly_d     = lly_q;
    urx_d     = urx_q;
    ury_d     = ury_q;
    rl_d      = rl_q;
    x_d       = x_q;
    y_d       = y_q;
    pend_d    = pend_q;
    ov_d      = ov_q;
    od_d      = od_q;
    os_d      = os_q;
    if (new_frame) begin
      sl_d   = cfg_slice_en_i;
      llx_d  = cfg_ll_x_i;
      lly_d  = cfg_ll_y_i;
      urx_d  = cfg_ur_x_i;
      ury_d  = cfg_ur_y_i;
      rl_d   = cfg_rowlen_i;
      fcnt_d = (fcnt_q >= cfg_drop_val_i) ? 6'd0 : fcnt_q + 6'd1;
      st_cur = keep ? S_ACTIVE : S_DROP;
      pend_d = keep;
    end
    cur_x  = new_frame ? '0 : x_q;
    cur_y  = new_frame ? '0 : y_q;
    in_win = ~sl_d |
             ((cur_x >= llx_d) && (cur_x <= urx_d) &&
              (cur_y >= lly_d) && (cur_y <= ury_d));
    emit   = acc & cfg_en_i & (st_cur == S_ACTIVE) & in_win;
    if (acc & cfg_en_i & (st_cur != S_IDLE)) begin
      if (cur_x == rl_d) begin
        x_d = '0;
        y_d = cur_y + ONE;
      end else begin
        x_d = cur_x + ONE;
        y_d = cur_y;
      end
    end
    state_d = cfg_en_i ? st_cur : S_IDLE;
    if (emit) begin
      ov_d   = 1'b1;
      od_d   = pix_data_i;
      os_d   = pend_d;
      pend_d = 1'b0;
    end else if (out_ready_i) begin
      ov_d = 1'b0;
    end
  end

  // State, shadow and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      fcnt_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sl_q    <= 1'b0;
      llx_q   <= '0;
      lly_q   <= '0;
      urx_q   <= '0;
      ury_q   <= '0;
      rl_q    <= '0;
      pend_q  <= 1'b0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      os_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sl_q    <= sl_d;
      llx_q   <= llx_d;
      lly_q   <= lly_d;
      urx_q   <= urx_d;
      ury_q   <= ury_d;
      rl_q    <= rl_d;
      pend_q  <= pend_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      os_q    <= os_d;
    end
  end

endmodule

// File: tb/tb_camera_frame_crop.sv
// Bench for camera_frame_crop: frame-level reference model
// plus directed scenarios with literal expectations.
module tb_camera_frame_crop;

  logic        clk;
  logic        rstn_i;
  logic        cfg_en_i;
  logic        cfg_slice_en_i;
  logic [15:0] cfg_ll_x_i, cfg_ll_y_i;
  logic [15:0] cfg_ur_x_i, cfg_ur_y_i;
  logic [15:0] cfg_rowlen_i;
  logic        cfg_drop_en_i;
  logic [5:0]  cfg_drop_val_i;
  logic        pix_valid_i;
  logic        pix_ready_o;
  logic [15:0] pix_data_i;
  logic        pix_sof_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [15:0] out_data_o;
  logic        out_sof_o;

  camera_frame_crop #(.DATA_W(16), .CNT_W(16)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i),
    .cfg_slice_en_i(cfg_slice_en_i),
    .cfg_ll_x_i(cfg_ll_x_i), .cfg_ll_y_i(cfg_ll_y_i),
    .cfg_ur_x_i(cfg_ur_x_i), .cfg_ur_y_i(cfg_ur_y_i),
    .cfg_rowlen_i(cfg_rowlen_i),
    .cfg_drop_en_i(cfg_drop_en_i), .cfg_drop_val_i(cfg_drop_val_i),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .pix_data_i(pix_data_i), .pix_sof_i(pix_sof_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_sof_o(out_sof_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [16:0] expq[$];
  logic [16:0] lg[$];
  int          m_mode;
  int          m_fcnt;
  bit          m_pend;
  longint      m_idx;
  bit          s_sl;
  int          s_llx, s_lly, s_urx, s_ury, s_rl;
  bit          last_acc;
  int          stall;
  int          nrdy0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    expq.delete();
    m_mode = 0;
    m_fcnt = 0;
    m_pend = 0;
    m_idx  = 0;
  endtask

  task automatic model_step(input bit acc);
    int x, y;
    bit keep, win;
    if (!cfg_en_i) begin
      m_mode = 0;
      return;
    end
    if (!acc) return;
    if (pix_sof_i) begin
      s_sl  = cfg_slice_en_i;
      s_llx = cfg_ll_x_i;
      s_lly = cfg_ll_y_i;
      s_urx = cfg_ur_x_i;
      s_ury = cfg_ur_y_i;
      s_rl  = cfg_rowlen_i;
      keep  = !cfg_drop_en_i || m_fcnt == 0;
      m_fcnt = (m_fcnt >= int'(cfg_drop_val_i)) ? 0 : m_fcnt + 1;
      m_mode = keep ? 1 : 2;
      m_idx  = 0;
      m_pend = keep;
    end
    if (m_mode == 1) begin
      x = int'(m_idx % (s_rl + 1));
      y = int'((m_idx / (s_rl + 1)) % 65536);
      win = !s_sl || (x >= s_llx && x <= s_urx &&
                      y >= s_lly && y <= s_ury);
      if (win) begin
        expq.push_back({m_pend, pix_data_i});
        m_pend = 0;
      end
    end
    m_idx++;
  endtask

  task automatic eval();
    bit acc;
    if (!rstn_i) begin
      model_reset();
      last_acc = 0;
      return;
    end
    acc = pix_valid_i && (expq.size() == 0 || out_ready_i);
    last_acc = acc;
    if (pix_ready_o === 1'b0) nrdy0++;
    chk("pix_ready", 32'(pix_ready_o),
        32'(expq.size() == 0 || out_ready_i));
    chk("out_valid", 32'(out_valid_o), 32'(expq.size() != 0));
    if (expq.size() != 0) begin
      chk("out_pix", 32'({out_sof_o, out_data_o}), 32'(expq[0]));
      if (out_ready_i) begin
        lg.push_back({out_sof_o, out_data_o});
        void'(expq.pop_front());
      end
    end
    model_step(acc);
  endtask

  task automatic cyc(input bit v, input bit s, input logic [15:0] d,
                     input bit r);
    pix_valid_i = v;
    pix_sof_i   = s;
    pix_data_i  = d;
    out_ready_i = r;
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [15:0] d, input bit s);
    int n;
    n = 0;
    do begin
      cyc(1'b1, s, d, stall == 0);
      if (stall > 0) stall--;
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) begin
      errors++;
      $display("FAIL px_timeout: got no accept expected accept");
    end
  endtask

  task automatic drain();
    repeat (3) cyc(1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    repeat (2) cyc(1'b0, 1'b0, 16'h0, 1'b1);
    rstn_i = 1'b1;
    lg.delete();
  endtask

  task automatic set_win(input int lx, input int ly,
                         input int ux, input int uy);
    cfg_ll_x_i = 16'(lx);
    cfg_ll_y_i = 16'(ly);
    cfg_ur_x_i = 16'(ux);
    cfg_ur_y_i = 16'(uy);
  endtask

  int crop_idx[6] = '{10, 11, 12, 18, 19, 20};
  bit ok;

  initial begin
    rstn_i = 0; cfg_en_i = 1; cfg_slice_en_i = 0;
    set_win(0, 0, 0, 0);
    cfg_rowlen_i = 16'd3; cfg_drop_en_i = 0; cfg_drop_val_i = 0;
    pix_valid_i = 0; pix_sof_i = 0; pix_data_i = 0; out_ready_i = 1;
    stall = 0; nrdy0 = 0;
    model_reset();
    do_reset();
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_sof", 32'(out_sof_o), 32'd0);
    chk("rst_data", 32'(out_data_o), 32'd0);
    chk("rst_ready", 32'(pix_ready_o), 32'd1);

    // pass-through
    for (int i = 0; i < 8; i++) px(16'(16'h100 + i), i == 0);
    drain();
    chk("pt_count", lg.size(), 8);
    chk("pt_first", 32'(lg[0]), 32'h10100);
    chk("pt_second", 32'(lg[1]), 32'h00101);
    chk("pt_last", 32'(lg[7]), 32'h00107);

    // crop
    do_reset();
    cfg_rowlen_i = 16'd7; cfg_slice_en_i = 1;
    set_win(2, 1, 4, 2);
    for (int i = 0; i < 32; i++) px(16'(i), i == 0);
    drain();
    chk("crop_count", lg.size(), 6);
    ok = lg.size() == 6;
    for (int k = 0; k < 6 && ok; k++)
      if (lg[k][15:0] != 16'(crop_idx[k])) ok = 0;
    chk("crop_idx", 32'(ok), 32'd1);
    chk("crop_sof0", 32'(lg[0]), 32'h1000a);
    chk("crop_sof1", 32'(lg[1][16]), 32'd0);

    // decimation
    do_reset();
    cfg_slice_en_i = 0; cfg_rowlen_i = 16'd3;
    cfg_drop_en_i = 1; cfg_drop_val_i = 6'd2;
    for (int f = 0; f < 6; f++)
      for (int i = 0; i < 4; i++) px(16'(f * 16 + i), i == 0);
    drain();
    chk("dec_count", lg.size(), 8);
    chk("dec_f0", 32'(lg[0]), 32'h10000);
    chk("dec_f3", 32'(lg[4]), 32'h10030);
    chk("dec_last", 32'(lg[7]), 32'h00033);
    cfg_drop_en_i = 0;

    // backpressure
    do_reset();
    nrdy0 = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) stall = 5;
      px(16'(16'h40 + i), i == 0);
    end
    drain();
    chk("bp_stall", nrdy0, 5);
    ok = lg.size() == 10;
    for (int k = 0; k < 10 && ok; k++)
      if (lg[k][15:0] != 16'(16'h40 + k)) ok = 0;
    chk("bp_seq", 32'(ok), 32'd1);

    // mid-frame window change and early sof
    do_reset();
    cfg_slice_en_i = 1; cfg_rowlen_i = 16'd3;
    set_win(0, 0, 1, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) set_win(0, 1, 1, 1);
      px(16'(i), i == 0);
    end
    for (int i = 0; i < 8; i++) px(16'(16'h10 + i), i == 0);
    drain();
    chk("mid_count", lg.size(), 4);
    chk("mid_0", 32'(lg[0]), 32'h10000);
    chk("mid_1", 32'(lg[1]), 32'h00001);
    chk("mid_2", 32'(lg[2]), 32'h10014);
    chk("mid_3", 32'(lg[3]), 32'h00015);

    // inverted window
    do_reset();
    cfg_rowlen_i = 16'd7;
    set_win(5, 0, 2, 3);
    for (int i = 0; i < 16; i++) px(16'(i), i == 0);
    drain();
    chk("inv_count", lg.size(), 0);

    // enable dropped mid-frame
    do_reset();
    cfg_slice_en_i = 0; cfg_rowlen_i = 16'd3;
    for (int i = 0; i < 3; i++) px(16'(i), i == 0);
    cfg_en_i = 0;
    cyc(1'b0, 1'b0, 16'h0, 1'b1);
    cfg_en_i = 1;
    px(16'h3, 1'b0);
    px(16'h4, 1'b0);
    px(16'h20, 1'b1);
    px(16'h21, 1'b0);
    drain();
    chk("en_count", lg.size(), 5);
    chk("en_resume", 32'(lg[3]), 32'h10020);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 29) == 0) begin
        cfg_slice_en_i = 1'($urandom_range(0, 1));
        set_win($urandom_range(0, 8), $urandom_range(0, 4),
                $urandom_range(0, 8), $urandom_range(0, 4));
        cfg_rowlen_i   = 16'($urandom_range(0, 7));
        cfg_drop_en_i  = 1'($urandom_range(0, 1));
        cfg_drop_val_i = 6'($urandom_range(0, 3));
      end
      cfg_en_i = $urandom_range(0, 99) != 0;
      rstn_i   = $urandom_range(0, 499) != 0;
      cyc($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
          16'($urandom), $urandom_range(0, 9) < 7);
    end
    rstn_i = 1;
    cfg_en_i = 1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/camera_frame_crop.md
CAMERA_FRAME_CROP -- requirements
Module: camera_frame_crop

Interface
REQ-001 Parameter DATA_W, default 16: pixel data width.
REQ-002 Parameter CNT_W, default 16: width of the x, y and configuration coordinate values.
REQ-003 clk_i  in  1  single clock; all logic is rising-edge.
REQ-004 rstn_i  in  1  synchronous, active-low reset.
REQ-005 cfg_en_i  in  1  enables processing of the incoming stream.
REQ-006 cfg_slice_en_i  in  1  enables window cropping.
REQ-007 cfg_ll_x_i, cfg_ll_y_i  in  CNT_W each  lower-left window corner (inclusive).
REQ-008 cfg_ur_x_i, cfg_ur_y_i  in  CNT_W each  upper-right window corner (inclusive).
REQ-009 cfg_rowlen_i  in  CNT_W  pixels per line minus one.
REQ-010 cfg_drop_en_i  in  1  enables frame decimation.
REQ-011 cfg_drop_val_i  in  6  keeps 1 of every cfg_drop_val_i+1 frames.
REQ-012 pix_valid_i / pix_ready_o  in / out  1  input handshake.
REQ-013 pix_data_i  in  DATA_W  input pixel.
REQ-014 pix_sof_i  in  1  marks the first pixel of a frame.
REQ-015 out_valid_o / out_ready_i  out / in  1  output handshake.
REQ-016 out_data_o  out  DATA_W  output pixel.
REQ-017 out_sof_o  out  1  marks the first emitted pixel of a kept frame.

Function
REQ-018 An input pixel is accepted when pix_valid_i and pix_ready_o are both 1.
- pix_ready_o = ~out_valid_o | out_ready_i.
- Output is a single register stage; latency is 1 cycle from acceptance to out_valid_o.
REQ-019 The FSM has three states: IDLE, ACTIVE, DROP.
- IDLE: accepted pixels are discarded.
- Accepted pixel with sof while cfg_en_i=1: go to ACTIVE if the frame is kept, otherwise go to DROP.
REQ-020 A sof pixel accepted in ACTIVE or DROP starts a new frame.
- The keep/drop decision is made again.
- Counters restart.
REQ-021 cfg_en_i=0 forces IDLE at the next edge.
- A pending output pixel still drains.
REQ-022 At each accepted sof in enabled operation:
- cfg_slice_en_i, the corner inputs and cfg_rowlen_i are latched into shadow registers.
- Mid-frame changes to these inputs have no effect until the next sof.
REQ-023 Frame counter fcnt (6 bit), updated on each accepted sof:
- A frame is kept when cfg_drop_en_i=0 or fcnt=0.
- fcnt then increments, wrapping to 0 after reaching cfg_drop_val_i.
- cfg_drop_val_i=0 keeps every frame.
REQ-024 Coordinate counters x, y:
- A sof pixel has coordinates (0,0).
- Each subsequent accepted pixel increments x.
- When x equals the shadowed rowlen, x wraps to 0 and y increments.
- y wraps modulo 2^CNT_W.
REQ-025 In ACTIVE, a pixel is emitted if either:
- the shadowed slice enable is 0, or
- ll_x<=x<=ur_x and ll_y<=y<=ur_y (unsigned compare).
If ll exceeds ur on either axis, nothing is emitted.
REQ-026 In DROP, pixels are accepted and never emitted.
REQ-027 out_sof_o = 1 on the first emitted pixel after a kept sof, and 0 on all later pixels of that frame.
REQ-028 While out_valid_o=1 and out_ready_i=0:
- out_data_o and out_sof_o hold stable.
- pix_ready_o = 0.
REQ-029 Simultaneous output drain and input acceptance in one cycle is supported with no bubble, giving a throughput of 1 pixel/cycle.

Reset
REQ-030 When rstn_i=0 at an edge, all of the following are cleared:
- state=IDLE, x=y=0, fcnt=0, shadows=0.
- out_valid_o=0, out_sof_o=0, out_data_o=0, so pix_ready_o=1.
REQ-031 Reset asserted mid-frame discards any pending output pixel.
- Processing resumes only at the next accepted sof.

Verification
REQ-032 Pass-through: slice off, drop off, rowlen=3, 8 pixels with sof on the first, out_ready=1 -> 8 outputs 1 cycle delayed; out_sof_o on the first only.
REQ-033 Crop: rowlen=7, ll=(2,1), ur=(4,2), 32-pixel frame -> exactly 6 outputs, i.e. pixel indices 10,11,12,18,19,20; out_sof_o on index 10.
REQ-034 Decimation: drop_en=1, drop_val=2, 6 frames of 4 pixels -> only frames 0 and 3 emitted.
REQ-035 Backpressure: out_ready=0 for 5 cycles mid-stream -> pix_ready_o=0 for those cycles; output held stable; no loss or duplication after release.
REQ-036 Mid-frame: change ll/ur mid-frame, then issue a new sof before frame end -> the old window applies until the sof; the new frame restarts at (0,0) with the new window.
REQ-037 Corner cases:
- ll_x>ur_x -> zero outputs.
- cfg_en_i deasserted mid-frame -> IDLE; no outputs until the next sof with enable=1.
